// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core: datapath widths, ALU and
// writeback encodings, and the ID/EX control bundle layout.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REGW_DEFAULT = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_control;
    } id_ex_ctrl_t;

    localparam int CTRL_W = $bits(id_ex_ctrl_t);

endpackage

// File: rtl/pipe_ctrl_reg.sv
// Pipeline flop block with flush-over-stall priority; reset and flush both
// load the BUBBLE value.
module pipe_ctrl_reg #(
    parameter int           W      = 1,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         stall_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // NOTE: q_d gets its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (flush_i) begin
            q_d = BUBBLE;
        end else if (!stall_i) begin
            q_d = d_i;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: a control bundle (squashed when the decode slot is
// invalid) and a data bundle, both bubbled by flush and held by stall.
module id_ex_register
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int REGW = REGW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic            reg_write_d,
    input  logic            mem_write_d,
    input  logic            jump_d,
    input  logic            branch_d,
    input  logic            alu_src_d,
    input  logic [1:0]      result_src_d,
    input  logic [2:0]      alu_control_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic [REGW-1:0] rs1_d,
    input  logic [REGW-1:0] rs2_d,
    input  logic [REGW-1:0] rd_d,
    output logic            valid_e,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic            jump_e,
    output logic            branch_e,
    output logic            alu_src_e,
    output logic [1:0]      result_src_e,
    output logic [2:0]      alu_control_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e,
    output logic [REGW-1:0] rs1_e,
    output logic [REGW-1:0] rs2_e,
    output logic [REGW-1:0] rd_e
);

    localparam int DATA_W = 5 * XLEN + 3 * REGW;

    id_ex_ctrl_t       ctrl_d;
    id_ex_ctrl_t       ctrl_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    // An invalid decode slot enters EX with the same control as a bubble.
    always_comb begin
        ctrl_d = '0;
        if (valid_d) begin
            ctrl_d.valid       = 1'b1;
            ctrl_d.reg_write   = reg_write_d;
            ctrl_d.mem_write   = mem_write_d;
            ctrl_d.jump        = jump_d;
            ctrl_d.branch      = branch_d;
            ctrl_d.alu_src     = alu_src_d;
            ctrl_d.result_src  = result_src_d;
            ctrl_d.alu_control = alu_control_d;
        end
    end

    assign data_d = {rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d};

    pipe_ctrl_reg #(
        .W      (CTRL_W),
        .BUBBLE ('0)
    ) u_ctrl_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_e),
        .stall_i (stall_e),
        .d_i     (ctrl_d),
        .q_o     (ctrl_q)
    );

    pipe_ctrl_reg #(
        .W      (DATA_W),
        .BUBBLE ('0)
    ) u_data_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_e),
        .stall_i (stall_e),
        .d_i     (data_d),
        .q_o     (data_q)
    );

    assign valid_e       = ctrl_q.valid;
    assign reg_write_e   = ctrl_q.reg_write;
    assign mem_write_e   = ctrl_q.mem_write;
    assign jump_e        = ctrl_q.jump;
    assign branch_e      = ctrl_q.branch;
    assign alu_src_e     = ctrl_q.alu_src;
    assign result_src_e  = ctrl_q.result_src;
    assign alu_control_e = ctrl_q.alu_control;

    assign {rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e} = data_q;

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register for the 5-stage pipelined RISC-V core. It captures the decode-stage control bundle, including the 3-bit ALUControl from alu_decoder, along with operands, immediate, PC values and register indices, and presents them to the execute stage one cycle later. The hazard unit drives stall (hold) and flush (bubble insertion) into it.

## Interface
Parameters:
- XLEN, 32, datapath width for operands, immediate and PC.
- REGW, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall_e  in  1  hold current contents
- flush_e  in  1  replace next contents with a bubble
- valid_d  in  1  decode slot holds a real instruction
- reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d  in  1 each  decode control bits
- result_src_d  in  2  writeback mux select
- alu_control_d  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
- rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d  in  XLEN each  operands, immediate, PCs
- rs1_d, rs2_d, rd_d  in  REGW each  register indices (rs1/rs2 are used for forwarding)
- the same set with suffix _e, plus valid_e  out  same widths  registered execute-stage copies

## Operation
- Every output is a flop. There is no combinational path from input to output.
- On each rising clk edge, priority is: flush_e, then stall_e, then normal load.
- Flush (bubble): valid_e=0. All control bits go to 0 and alu_control_e to 000. All data and index fields go to 0, so rd_e=x0 and the bubble writes nothing.
- Stall: all _e outputs keep their values.
- Load: every _e output takes its _d input.
- When valid_d=0 on a load, control bits are forced to 0, as for a bubble. Data fields are still captured.
- alu_control_d passes through unchanged. Codes 100, 110 and 111 are not filtered.
- Reset: the register asynchronously clears to the bubble state. All outputs are 0.

## Timing
- Latency is 1 cycle from _d inputs to _e outputs.
- Reset asserts immediately (asynchronous). After release, the first load happens on the first clk edge where rst is low.
- Reset asserted mid-stall or mid-flush: reset wins, and the outputs read bubble.
- flush_e and stall_e asserted in the same cycle: flush wins, and a bubble is loaded.
- A stall held for N cycles keeps the outputs constant for N cycles. The next edge with stall low loads the then-current _d.
- No state machine. Throughput is one instruction per cycle when neither stall nor flush is asserted.

## Structure
- The shared package riscv_pkg holds:
  - ALU control localparams: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - ResultSrc encodings.
  - XLEN and REGW defaults.
- alu_decoder and the main decoder share these constants.
- Sub-module pipe_ctrl_reg: a single flop block parameterised by width, taking rst, flush, stall and a bubble value. It is instantiated once for the control bundle (bubble = 0) and once for the data bundle.

## Test plan
- Reset: assert rst asynchronously between edges -> all outputs 0 immediately, before the next edge; valid_e=0.
- Load: rd1_d=0x0000_0005, rd2_d=0x0000_0003, alu_control_d=001, reg_write_d=1, rd_d=7 -> one edge later: rd1_e=5, rd2_e=3, alu_control_e=001, reg_write_e=1, rd_e=7, valid_e=1.
- Stall: with the load above held, assert stall_e for 3 cycles while changing _d to alu_control_d=010, rd_d=9 -> outputs hold 001/7 for 3 cycles, then show 010/9 one edge after stall drops.
- Flush with stall: flush_e=1 and stall_e=1 with reg_write_d=1, mem_write_d=1 -> next edge: all control 0, rd_e=0, valid_e=0.
- Invalid decode: valid_d=0, reg_write_d=1, branch_d=1, rd1_d=0xDEAD_BEEF -> reg_write_e=0, branch_e=0, rd1_e=0xDEAD_BEEF, valid_e=0.
- Reset mid-stall: stall_e=1 with loaded state, then pulse rst -> outputs clear; after rst drops with stall_e=0, the next edge loads the current _d.
